// File: rtl/ip_tx_sequencer_if.sv
// Bus bundle between ip_tx_sequencer, its transmit sources and the MAC TX sink.
// master = sequencer side; slave = sources plus downstream sink.
interface ip_tx_sequencer_if #(
    parameter int NSRC = 4,
    parameter int DW   = 32,
    parameter int BEW  = 2
);
    logic [NSRC-1:0]     src_start;
    logic [NSRC-1:0]     src_sel;
    logic [NSRC-1:0]     src_rd;
    logic [NSRC-1:0]     src_rdy;
    logic [NSRC*DW-1:0]  src_data;
    logic [NSRC*BEW-1:0] src_be;
    logic [DW-1:0]       out_data;
    logic [BEW-1:0]      out_be;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output src_start, src_sel, src_rd, out_data, out_be, out_valid,
        input  src_rdy, src_data, src_be, out_ready
    );

    modport slave (
        input  src_start, src_sel, src_rd, out_data, out_be, out_valid,
        output src_rdy, src_data, src_be, out_ready
    );
endinterface

// File: rtl/ip_tx_sequencer.sv
// Frame sequencer: drains each enabled transmit source in ascending index order
// into one registered valid/ready word stream, reporting frame done/error status.
module ip_tx_sequencer #(
    parameter int NSRC  = 4,
    parameter int DW    = 32,
    parameter int BEW   = 2,
    parameter int TMO_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_frm_start,
    input  logic [NSRC-1:0]  i_frm_mask,
    output logic             o_busy,
    output logic             o_frm_done,
    output logic             o_frm_err,
    output logic [15:0]      o_frm_words,
    ip_tx_sequencer_if.master io_bus
);
    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
    // Last WAIT cycle before giving up: the counter would reach 2^TMO_W-1 here.
    localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XFER,
        ST_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;

    logic [NSRC-1:0]   r_mask;
    logic [IW-1:0]     r_cur;
    logic              r_seen;
    logic [TMO_W-1:0]  r_tmo;
    logic [NSRC-1:0]   r_srcStart;
    logic [DW-1:0]     r_outData;
    logic [BEW-1:0]    r_outBe;
    logic              r_outValid;
    logic              r_frmDone;
    logic              r_frmErr;
    logic [15:0]       r_frmWords;

    logic [DW-1:0]     w_srcWord [NSRC];
    logic [BEW-1:0]    w_srcBe   [NSRC];
    logic [IW-1:0]     w_firstIdx;
    logic [IW-1:0]     w_nextIdx;
    logic              w_hasNext;
    logic [NSRC-1:0]   w_curHot;
    logic              w_curRdy;
    logic              w_stageFree;
    logic              w_accept;
    logic              w_rdAny;
    logic              w_frmAccept;
    logic              w_emptyFrame;
    logic              w_timeout;
    logic              w_switch;
    logic              w_finish;

    function automatic logic [NSRC-1:0] oneHot(input logic [IW-1:0] idx);
        return NSRC'(1) << idx;
    endfunction

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            w_srcWord[i] = io_bus.src_data[i*DW +: DW];
            w_srcBe[i]   = io_bus.src_be[i*BEW +: BEW];
        end
    end

    // Lowest enabled source of the incoming mask, and next enabled source above cur.
    always_comb begin
        w_firstIdx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (i_frm_mask[i]) begin
                w_firstIdx = IW'(i);
            end
        end
        w_nextIdx = '0;
        w_hasNext = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_cur))) begin
                w_nextIdx = IW'(i);
                w_hasNext = 1'b1;
            end
        end
    end

    assign w_curHot    = oneHot(r_cur);
    assign w_curRdy    = io_bus.src_rdy[r_cur];
    assign w_stageFree = !r_outValid || io_bus.out_ready;
    assign w_accept    = r_outValid && io_bus.out_ready;
    assign w_rdAny     = |io_bus.src_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_frmAccept  = 1'b0;
        w_emptyFrame = 1'b0;
        w_timeout    = 1'b0;
        w_switch     = 1'b0;
        w_finish     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_frm_start) begin
                    if (|i_frm_mask) begin
                        w_frmAccept = 1'b1;
                        w_stateNext = ST_WAIT;
                    end else begin
                        w_emptyFrame = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (w_curRdy) begin
                    w_stateNext = ST_XFER;
                end else if (r_tmo == TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_stateNext = ST_IDLE;
                end
            end
            ST_XFER: begin
                // rdy low after at least one read means the source is exhausted.
                if (!w_curRdy && r_seen) begin
                    if (w_hasNext) begin
                        w_switch    = 1'b1;
                        w_stateNext = ST_WAIT;
                    end else if (w_stageFree) begin
                        w_finish    = 1'b1;
                        w_stateNext = ST_IDLE;
                    end else begin
                        w_stateNext = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_stageFree) begin
                    w_finish    = 1'b1;
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy         = (r_state != ST_IDLE);
        io_bus.src_sel = '0;
        io_bus.src_rd  = '0;
        if (r_state == ST_WAIT || r_state == ST_XFER) begin
            io_bus.src_sel = w_curHot;
        end
        if (r_state == ST_XFER && w_curRdy && w_stageFree) begin
            io_bus.src_rd = w_curHot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask     <= '0;
            r_cur      <= '0;
            r_seen     <= 1'b0;
            r_tmo      <= '0;
            r_srcStart <= '0;
            r_outData  <= '0;
            r_outBe    <= '0;
            r_outValid <= 1'b0;
            r_frmDone  <= 1'b0;
            r_frmErr   <= 1'b0;
            r_frmWords <= '0;
        end else begin
            r_srcStart <= '0;
            r_frmDone  <= w_emptyFrame || w_finish;
            r_frmErr   <= w_timeout;

            if (w_frmAccept) begin
                r_mask     <= i_frm_mask;
                r_cur      <= w_firstIdx;
                r_srcStart <= oneHot(w_firstIdx);
            end else if (w_switch) begin
                r_cur      <= w_nextIdx;
                r_srcStart <= oneHot(w_nextIdx);
            end

            if (r_state == ST_WAIT && !w_curRdy && !w_timeout) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end else begin
                r_tmo <= '0;
            end

            if (r_state == ST_WAIT) begin
                r_seen <= 1'b0;
            end else if (w_rdAny) begin
                r_seen <= 1'b1;
            end

            // A read while the held word is accepted keeps the stage full.
            if (w_timeout) begin
                r_outValid <= 1'b0;
            end else if (w_rdAny) begin
                r_outData  <= w_srcWord[r_cur];
                r_outBe    <= w_srcBe[r_cur];
                r_outValid <= 1'b1;
            end else if (w_accept) begin
                r_outValid <= 1'b0;
            end

            if (w_frmAccept || w_emptyFrame) begin
                r_frmWords <= '0;
            end else if (w_accept && r_frmWords != 16'hFFFF) begin
                r_frmWords <= r_frmWords + 16'd1;
            end
        end
    end

    assign io_bus.src_start = r_srcStart;
    assign io_bus.out_data  = r_outData;
    assign io_bus.out_be    = r_outBe;
    assign io_bus.out_valid = r_outValid;
    assign o_frm_done       = r_frmDone;
    assign o_frm_err        = r_frmErr;
    assign o_frm_words      = r_frmWords;

    selOneHot: assert property (@(posedge clk) disable iff (rst) $onehot0(io_bus.src_sel));
    rdWithinSel: assert property (@(posedge clk) disable iff (rst) (io_bus.src_rd & ~io_bus.src_sel) == '0);
endmodule

// File: tb/tb_ip_tx_sequencer.sv
// Scoreboard bench for ip_tx_sequencer: behavioural sources feed random frames,
// expected words/starts are queued at issue time and popped by a negedge monitor.
module tb_ip_tx_sequencer;
    localparam int NSRC  = 4;
    localparam int DW    = 32;
    localparam int BEW   = 2;
    localparam int TMO_W = 8;
    localparam int MAXW  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            frmStart;
    logic [NSRC-1:0] frmMask;
    logic            busy;
    logic            frmDone;
    logic            frmErr;
    logic [15:0]     frmWords;

    ip_tx_sequencer_if #(.NSRC(NSRC), .DW(DW), .BEW(BEW)) bus ();

    ip_tx_sequencer #(.NSRC(NSRC), .DW(DW), .BEW(BEW), .TMO_W(TMO_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_frm_start (frmStart),
        .i_frm_mask  (frmMask),
        .o_busy      (busy),
        .o_frm_done  (frmDone),
        .o_frm_err   (frmErr),
        .o_frm_words (frmWords),
        .io_bus      (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0]  srcData [NSRC][MAXW];
    logic [BEW-1:0] srcBe   [NSRC][MAXW];
    int             srcLen    [NSRC];
    int             srcBase   [NSRC];
    int             readCount [NSRC];

    logic [BEW+DW-1:0] expQ[$];
    int                expStartQ[$];
    logic [BEW+DW-1:0] expWord;
    logic [NSRC-1:0]   expHot;
    logic [NSRC-1:0]   lastMask;
    int                expIdx;
    int                expTotal;
    int                expEnabled;
    int                doneBase;
    int                errBase;
    int                readyMode;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int doneCount = 0;
    int errCount = 0;
    int frameAccepts = 0;
    int frameStartCycle = 0;
    int firstValidCycle = 0;
    int startPulseCycle = 0;
    int doneCycle = 0;
    int errCycle = 0;
    bit sawValid = 1'b0;
    bit sawPulse = 1'b0;

    // Source model: a word list per source, pointer advanced by src_rd, rdy while words remain.
    always_comb begin
        bus.src_rdy  = '0;
        bus.src_data = '0;
        bus.src_be   = '0;
        for (int i = 0; i < NSRC; i++) begin
            bus.src_rdy[i]             = (readCount[i] - srcBase[i]) < srcLen[i];
            bus.src_data[i*DW +: DW]   = srcData[i][(readCount[i] - srcBase[i]) & (MAXW - 1)];
            bus.src_be[i*BEW +: BEW]   = srcBe[i][(readCount[i] - srcBase[i]) & (MAXW - 1)];
        end
    end

    always @(posedge clk) begin
        cycle <= cycle + 1;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.src_rd[i]) begin
                readCount[i] <= readCount[i] + 1;
            end
        end
    end

    // Downstream ready: 0 always, 1 toggling, 2 half random, 3 mostly ready.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                1:       bus.out_ready = ~bus.out_ready;
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                3:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted word and every src_start pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (frmStart && !busy) begin
                frameStartCycle = cycle;
                sawValid        = 1'b0;
                sawPulse        = 1'b0;
                frameAccepts    = 0;
            end
            if (bus.src_start != '0) begin
                if (!sawPulse) begin
                    startPulseCycle = cycle;
                    sawPulse        = 1'b1;
                end
                tests++;
                if (expStartQ.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL src_start_unexpected actual=%b required=none", bus.src_start);
                end else begin
                    expIdx = expStartQ.pop_front();
                    expHot = '0;
                    expHot[expIdx] = 1'b1;
                    if (bus.src_start !== expHot) begin
                        fails++;
                        $display("[TB] FAIL src_start_order actual=%b required=%b", bus.src_start, expHot);
                    end
                end
            end
            tests++;
            if (!$onehot0(bus.src_sel) || ((bus.src_rd & ~bus.src_sel) != '0) ||
                (bus.src_rd != '0 && bus.out_valid && !bus.out_ready)) begin
                fails++;
                $display("[TB] FAIL bus_rules actual sel=%b rd=%b valid=%b ready=%b required onehot0 sel, rd in sel, rd only with free stage",
                         bus.src_sel, bus.src_rd, bus.out_valid, bus.out_ready);
            end
            if (bus.out_valid && !sawValid) begin
                firstValidCycle = cycle;
                sawValid        = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                tests++;
                frameAccepts++;
                if (expQ.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL out_word_unexpected actual=%h required=none", {bus.out_be, bus.out_data});
                end else begin
                    expWord = expQ.pop_front();
                    if ({bus.out_be, bus.out_data} !== expWord) begin
                        fails++;
                        $display("[TB] FAIL out_word actual=%h required=%h", {bus.out_be, bus.out_data}, expWord);
                    end
                end
            end
            if (frmDone) begin
                doneCount++;
                doneCycle = cycle;
            end
            if (frmErr) begin
                errCount++;
                errCycle = cycle;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        tests++;
        if (actual !== required) begin
            fails++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic fillRandom();
        for (int i = 0; i < NSRC; i++) begin
            srcLen[i] = $urandom_range(1, 6);
            for (int k = 0; k < MAXW; k++) begin
                srcData[i][k] = $urandom;
                srcBe[i][k]   = BEW'($urandom_range(0, 3));
            end
        end
    endtask

    // IPv4 header on source 1: version 4, IHL 5, length 40, UDP to 192.168.0.199.
    task automatic loadIpHeader();
        fillRandom();
        srcLen[1]     = 5;
        srcData[1][0] = {4'h4, 4'h5, 8'h00, 16'd40};
        srcData[1][1] = 32'h1c46_4000;
        srcData[1][2] = 32'h4011_0000;
        srcData[1][3] = 32'hc0a8_0001;
        srcData[1][4] = 32'hc0a8_00c7;
        for (int k = 0; k < 5; k++) begin
            srcBe[1][k] = '1;
        end
    endtask

    // Queues the expected frame (enabled sources concatenated in index order) and pulses frm_start.
    task automatic applyStimulus(input logic [NSRC-1:0] mask);
        expTotal   = 0;
        expEnabled = 0;
        lastMask   = mask;
        doneBase   = doneCount;
        errBase    = errCount;
        for (int i = 0; i < NSRC; i++) begin
            srcBase[i] = readCount[i];
            if (mask[i]) begin
                expStartQ.push_back(i);
                expEnabled++;
                expTotal += srcLen[i];
                for (int k = 0; k < srcLen[i]; k++) begin
                    expQ.push_back({srcBe[i][k], srcData[i][k]});
                end
            end
        end
        frmMask  = mask;
        frmStart = 1'b1;
        @(posedge clk);
        #1;
        frmStart = 1'b0;
    endtask

    task automatic waitFrameEnd(input int budget);
        int c;
        c = 0;
        while (doneCount == doneBase && errCount == errBase && c < budget) begin
            @(posedge clk);
            c++;
        end
        tests++;
        if (c >= budget) begin
            fails++;
            $display("[TB] FAIL frame_end_wait actual=%0d cycles required=under %0d", c, budget);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkFrame(input bit timing);
        checkOutput("frm_done_count", doneCount - doneBase, 1);
        checkOutput("frm_err_count", errCount - errBase, 0);
        checkOutput("frm_words", frmWords, expTotal);
        checkOutput("words_left", expQ.size(), 0);
        checkOutput("starts_left", expStartQ.size(), 0);
        checkOutput("busy_after", busy, 0);
        for (int i = 0; i < NSRC; i++) begin
            checkOutput($sformatf("src%0d_reads", i), readCount[i] - srcBase[i], lastMask[i] ? srcLen[i] : 0);
        end
        if (timing) begin
            checkOutput("first_valid_latency", firstValidCycle - frameStartCycle, 3);
            checkOutput("frame_duration", doneCycle - frameStartCycle, 3 + expTotal + 2 * (expEnabled - 1));
        end
    endtask

    initial begin
        rst       = 1'b1;
        frmStart  = 1'b0;
        frmMask   = '0;
        readyMode = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_valid", bus.out_valid, 0);
        checkOutput("reset_sel_rd_start", {bus.src_sel, bus.src_rd, bus.src_start}, 0);
        checkOutput("reset_status", {frmDone, frmErr, frmWords}, 0);
        checkOutput("reset_data", bus.out_data, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] single source IP header, ready held high");
        loadIpHeader();
        readyMode = 0;
        applyStimulus(4'b0010);
        waitFrameEnd(100);
        checkOutput("src_start_latency", startPulseCycle - frameStartCycle, 1);
        checkFrame(1'b1);

        $display("[TB] single source IP header, ready toggling");
        loadIpHeader();
        readyMode = 1;
        applyStimulus(4'b0010);
        waitFrameEnd(200);
        checkFrame(1'b0);

        $display("[TB] three sources 2/5/3 words plus start while busy");
        fillRandom();
        srcLen[0] = 2;
        srcLen[1] = 5;
        srcLen[3] = 3;
        readyMode = 0;
        applyStimulus(4'b1011);
        repeat (4) @(posedge clk);
        #1;
        frmMask  = 4'b0100;
        frmStart = 1'b1;
        @(posedge clk);
        #1;
        frmStart = 1'b0;
        waitFrameEnd(200);
        checkFrame(1'b1);

        $display("[TB] empty mask frame");
        applyStimulus('0);
        waitFrameEnd(20);
        checkOutput("empty_done_latency", doneCycle - frameStartCycle, 1);
        checkFrame(1'b0);

        $display("[TB] source never ready, timeout");
        fillRandom();
        srcLen[0] = 0;
        applyStimulus(4'b0001);
        waitFrameEnd(400);
        checkOutput("tmo_err_count", errCount - errBase, 1);
        checkOutput("tmo_done_count", doneCount - doneBase, 0);
        checkOutput("tmo_err_latency", errCycle - frameStartCycle, 256);
        checkOutput("tmo_any_valid", sawValid, 0);
        checkOutput("tmo_busy", busy, 0);
        checkOutput("tmo_starts_left", expStartQ.size(), 0);

        $display("[TB] reset during third word");
        loadIpHeader();
        applyStimulus(4'b0010);
        for (int c = 0; c < 40 && frameAccepts < 2; c++) begin
            @(posedge clk);
        end
        #1;
        checkOutput("reset_point_words", frameAccepts, 2);
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_valid", bus.out_valid, 0);
        checkOutput("midrst_sel_rd_start", {bus.src_sel, bus.src_rd, bus.src_start}, 0);
        checkOutput("midrst_status", {frmDone, frmErr, frmWords}, 0);
        checkOutput("midrst_data", bus.out_data, 0);
        expQ.delete();
        expStartQ.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        doneBase = doneCount;
        errBase  = errCount;
        checkOutput("midrst_no_pulse", doneCount + errCount - doneBase - errBase, 0);

        $display("[TB] random frames");
        for (int f = 0; f < 16; f++) begin
            readyMode = $urandom_range(0, 3);
            fillRandom();
            applyStimulus(NSRC'($urandom_range(1, 15)));
            waitFrameEnd(800);
            checkFrame(readyMode == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
